// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder and its RAM.
// DMEM_STATS_EN (used by the top) enables the saturating statistics counters.
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Misaligned byte address, or word index beyond the 2^addr_w-word array.
  function automatic logic addr_err(input logic [31:0] addr, input int addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator (master) and the data memory responder (slave).
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// 2^ADDR_W x 32 single-port synchronous RAM, per-byte write enables, registered read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane writes and read-data register; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state data memory responder: IDLE -> WAIT -> RESP per request.
// Define DMEM_STATS_EN to build the saturating load/store/error counters.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic [STAT_W-1:0]    stat_rd,
  output logic [STAT_W-1:0]    stat_wr,
  output logic [STAT_W-1:0]    stat_err
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              accept_s;
  logic              enter_resp_s;
  logic              ram_we_s;
  logic              ram_re_s;
  logic [DATA_W-1:0] ram_rdata_s;

  // Next-state logic; the *_d request fields are what the RAM sees on the edge entering RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    err_d        = err_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    accept_s     = 1'b0;
    enter_resp_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept_s = 1'b1;
          write_d  = bus.req_write;
          err_d    = addr_err(bus.req_addr, ADDR_W);
          idx_d    = bus.req_addr[ADDR_W+1:2];
          wdata_d  = bus.req_wdata;
          be_d     = bus.req_be;
          if (WAIT_CYCLES == 0) begin
            state_d      = ST_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d      = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset on the committing edge suppresses the write, so a dropped request leaves memory intact.
  assign ram_we_s = enter_resp_s && write_d && !err_d && !reset;
  assign ram_re_s = enter_resp_s && !write_d && !err_d && !reset;

  // FSM and latched-request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      write_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      be_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .addr  (idx_d),
    .we    (ram_we_s),
    .be    (be_d),
    .wdata (wdata_d),
    .re    (ram_re_s),
    .rdata (ram_rdata_s)
  );

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_err   = (state_q == ST_RESP) && err_q;
  assign bus.rsp_rdata = ((state_q == ST_RESP) && !err_q && !write_q) ? ram_rdata_s : {DATA_W{1'b0}};

`ifdef DMEM_STATS_EN
  logic [STAT_W-1:0] stat_rd_q, stat_rd_d;
  logic [STAT_W-1:0] stat_wr_q, stat_wr_d;
  logic [STAT_W-1:0] stat_err_q, stat_err_d;

  // Each accepted request bumps exactly one class; errors never count as loads or stores.
  always_comb begin
    stat_rd_d  = stat_rd_q;
    stat_wr_d  = stat_wr_q;
    stat_err_d = stat_err_q;
    if (accept_s) begin
      if (err_d) begin
        stat_err_d = sat_inc(stat_err_q);
      end else if (write_d) begin
        stat_wr_d = sat_inc(stat_wr_q);
      end else begin
        stat_rd_d = sat_inc(stat_rd_q);
      end
    end else begin
      stat_rd_d = stat_rd_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_rd_q  <= {STAT_W{1'b0}};
      stat_wr_q  <= {STAT_W{1'b0}};
      stat_err_q <= {STAT_W{1'b0}};
    end else begin
      stat_rd_q  <= stat_rd_d;
      stat_wr_q  <= stat_wr_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_rd  = stat_rd_q;
  assign stat_wr  = stat_wr_q;
  assign stat_err = stat_err_q;
`else
  assign stat_rd  = {STAT_W{1'b0}};
  assign stat_wr  = {STAT_W{1'b0}};
  assign stat_err = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: instance 0 has 2 wait states, instance 1 has none.
// A word-array model predicts every response; stats are expected only when DMEM_STATS_EN is defined.
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int ADDR_W = 8;
  localparam int NDUT   = 2;
`ifdef DMEM_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0]        reset;
  logic [NDUT-1:0]        req_valid, req_write, rsp_ready;
  logic [NDUT-1:0][31:0]  req_addr, req_wdata;
  logic [NDUT-1:0][3:0]   req_be;
  wire  [NDUT-1:0]        req_ready, rsp_valid, rsp_err;
  wire  [NDUT-1:0][31:0]  rsp_rdata;
  wire  [NDUT-1:0][15:0]  stat_rd, stat_wr, stat_err;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    data_mem_responder_if bus ();
    assign bus.req_valid = req_valid[g];
    assign bus.req_write = req_write[g];
    assign bus.req_addr  = req_addr[g];
    assign bus.req_wdata = req_wdata[g];
    assign bus.req_be    = req_be[g];
    assign bus.rsp_ready = rsp_ready[g];
    assign req_ready[g]  = bus.req_ready;
    assign rsp_valid[g]  = bus.rsp_valid;
    assign rsp_rdata[g]  = bus.rsp_rdata;
    assign rsp_err[g]    = bus.rsp_err;

    data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(g == 0 ? 2 : 0)) u_dut (
      .clk      (clk),
      .reset    (reset[g]),
      .bus      (bus),
      .stat_rd  (stat_rd[g]),
      .stat_wr  (stat_wr[g]),
      .stat_err (stat_err[g])
    );
  end

  // Behavioural model state.
  bit [31:0] mmem [NDUT][256];
  bit        pend_v [NDUT];
  bit        pend_res [NDUT];
  bit        pend_w [NDUT];
  bit [31:0] pend_a [NDUT];
  bit [31:0] pend_d [NDUT];
  bit [3:0]  pend_be [NDUT];
  bit [31:0] exp_rd [NDUT];
  bit        exp_err [NDUT];
  int        cnt_rd [NDUT];
  int        cnt_wr [NDUT];
  int        cnt_err [NDUT];
  bit        chk_on = 1'b0;
  int        vectors = 0;
  int        miscompares = 0;

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit model_err(input bit [31:0] a);
    return (a % 4 != 0) || (a >= 32'd1024);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < NDUT; d++) begin
        check($sformatf("stat_rd%0d", d),  {16'h0, stat_rd[d]},  STATS_ON ? cnt_rd[d]  : 32'd0);
        check($sformatf("stat_wr%0d", d),  {16'h0, stat_wr[d]},  STATS_ON ? cnt_wr[d]  : 32'd0);
        check($sformatf("stat_err%0d", d), {16'h0, stat_err[d]}, STATS_ON ? cnt_err[d] : 32'd0);
        if (reset[d]) begin
          pend_v[d] = 1'b0; pend_res[d] = 1'b0;
          cnt_rd[d] = 0; cnt_wr[d] = 0; cnt_err[d] = 0;
        end else if (rsp_valid[d]) begin
          if (!pend_v[d]) begin
            check($sformatf("unexpected_rsp%0d", d), 32'd1, 32'd0);
          end else begin
            if (!pend_res[d]) begin
              pend_res[d] = 1'b1;
              exp_err[d]  = model_err(pend_a[d]);
              exp_rd[d]   = (exp_err[d] || pend_w[d]) ? 32'd0 : mmem[d][pend_a[d] / 4];
              if (pend_w[d] && !exp_err[d]) begin
                for (int i = 0; i < 4; i++) begin
                  if (pend_be[d][i]) begin
                    mmem[d][pend_a[d] / 4][8*i +: 8] = pend_d[d][8*i +: 8];
                  end
                end
              end
            end
            check($sformatf("rsp_rdata%0d", d), rsp_rdata[d], exp_rd[d]);
            check($sformatf("rsp_err%0d", d), {31'd0, rsp_err[d]}, {31'd0, exp_err[d]});
            check($sformatf("req_ready_resp%0d", d), {31'd0, req_ready[d]}, 32'd0);
            if (rsp_ready[d]) begin
              pend_v[d] = 1'b0; pend_res[d] = 1'b0;
            end
          end
        end else if (pend_v[d]) begin
          check($sformatf("req_ready_wait%0d", d), {31'd0, req_ready[d]}, 32'd0);
        end else begin
          check($sformatf("req_ready_idle%0d", d), {31'd0, req_ready[d]}, 32'd1);
        end
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the response handshake.
  task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input int hold, input bit junk,
                     output logic [31:0] got_rd, output logic got_err);
    int n;
    n = 0;
    while (!req_ready[d] && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) check("req_ready_timeout", 32'd0, 32'd1);
    req_valid[d] = 1'b1; req_write[d] = w; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be;
    @(posedge clk);
    pend_v[d] = 1'b1; pend_res[d] = 1'b0;
    pend_w[d] = w; pend_a[d] = a; pend_d[d] = wd; pend_be[d] = be;
    if (model_err(a)) cnt_err[d]++;
    else if (w) cnt_wr[d]++;
    else cnt_rd[d]++;
    #1;
    req_valid[d] = 1'b0; req_addr[d] = $urandom; req_wdata[d] = $urandom; req_write[d] = $urandom_range(0, 1);
    n = 1;
    @(negedge clk);
    while (!rsp_valid[d] && n < 50) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check($sformatf("latency%0d", d), n, wait_of(d) + 1);
    got_rd = rsp_rdata[d]; got_err = rsp_err[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (junk) begin
        req_valid[d] = 1'b1; req_write[d] = 1'b1; req_addr[d] = 32'h10;
        req_wdata[d] = 32'h1234_5678; req_be[d] = 4'hF;
      end
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0; rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
  endtask

  task automatic do_reset(input int d);
    reset[d] = 1'b1;
    @(posedge clk); #1;
    reset[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    bit   [31:0] a;
    int          r;
    reset = '1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1 chk_on = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check("reset_req_ready", {31'd0, req_ready[d]}, 32'd1);
      check("reset_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
      check("reset_rsp_rdata", rsp_rdata[d], 32'd0);
      check("reset_rsp_err",   {31'd0, rsp_err[d]}, 32'd0);
    end
    @(posedge clk); #1;
    reset = '0;

    // Known contents for the first 32 words of each memory.
    for (int d = 0; d < NDUT; d++) begin
      for (int w = 0; w < 32; w++) begin
        txn(d, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, 1'b0, rd, er);
      end
    end

    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, rd, er);
    check("store_err", {31'd0, er}, 32'd0);
    check("store_rdata", rd, 32'd0);
    txn(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, 1'b0, rd, er);
    check("load_deadbeef", rd, 32'hDEAD_BEEF);
    check("load_deadbeef_err", {31'd0, er}, 32'd0);
    txn(0, 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0, 1'b0, rd, er);
    txn(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, 1'b0, rd, er);
    check("byte_lane0", rd, 32'hDEAD_BEAA);
    txn(0, 1'b0, 32'h13, 32'd0, 4'h0, 0, 1'b0, rd, er);
    check("misaligned_err", {31'd0, er}, 32'd1);
    check("misaligned_rdata", rd, 32'd0);
    txn(0, 1'b0, 32'h400, 32'd0, 4'h0, 0, 1'b0, rd, er);
    check("range_err", {31'd0, er}, 32'd1);
    check("range_rdata", rd, 32'd0);
    txn(0, 1'b1, 32'h11, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, rd, er);
    check("store_misaligned_err", {31'd0, er}, 32'd1);
    txn(0, 1'b0, 32'h10, 32'd0, 4'h0, 5, 1'b1, rd, er);
    check("stall_load", rd, 32'hDEAD_BEAA);
    txn(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, 1'b0, rd, er);
    check("junk_ignored", rd, 32'hDEAD_BEAA);
    txn(0, 1'b1, 32'h10, 32'h5555_5555, 4'h0, 0, 1'b0, rd, er);
    check("be0_err", {31'd0, er}, 32'd0);
    txn(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, 1'b0, rd, er);
    check("be0_noop", rd, 32'hDEAD_BEAA);

    // Reset while the store to 0x20 is still waiting.
    txn(0, 1'b1, 32'h20, 32'h0123_4567, 4'hF, 0, 1'b0, rd, er);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'hCAFE_F00D; req_be[0] = 4'hF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    do_reset(0);
    @(negedge clk);
    check("rst_wait_idle", {31'd0, req_ready[0]}, 32'd1);
    check("rst_wait_no_rsp", {31'd0, rsp_valid[0]}, 32'd0);
    @(posedge clk); #1;
    txn(0, 1'b0, 32'h20, 32'd0, 4'h0, 0, 1'b0, rd, er);
    check("rst_wait_prior", rd, 32'h0123_4567);

    // Zero-wait instance: counter check from a fresh reset.
    do_reset(1);
    txn(1, 1'b0, 32'h0, 32'd0, 4'h0, 0, 1'b0, rd, er);
    txn(1, 1'b1, 32'h8, 32'hA5A5_0000, 4'hC, 1, 1'b0, rd, er);
    txn(1, 1'b0, 32'h8, 32'd0, 4'h0, 0, 1'b0, rd, er);
    txn(1, 1'b0, 32'h2, 32'd0, 4'h0, 0, 1'b0, rd, er);
    check("w0_err", {31'd0, er}, 32'd1);
    txn(1, 1'b1, 32'h4, 32'h0000_1234, 4'h3, 0, 1'b0, rd, er);
    txn(1, 1'b0, 32'h4, 32'd0, 4'h0, 0, 1'b0, rd, er);
    check("w0_stat_rd",  {16'h0, stat_rd[1]},  STATS_ON ? 32'd3 : 32'd0);
    check("w0_stat_wr",  {16'h0, stat_wr[1]},  STATS_ON ? 32'd2 : 32'd0);
    check("w0_stat_err", {16'h0, stat_err[1]}, STATS_ON ? 32'd1 : 32'd0);

    for (int k = 0; k < 120; k++) begin
      int d;
      d = k % NDUT;
      r = $urandom_range(0, 9);
      if (r == 0) a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      else if (r == 1) a = ($urandom | 32'h400) & 32'hFFFF_FFFC;
      else a = 32'($urandom_range(0, 31) * 4);
      txn(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)), rd, er);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
